// File: rtl/if_id_fetch_queue_pkg.sv
// Types and constants shared by the fetch queue RTL and its bench.
// The packet layout is {pc, data, taken_branch}, with pc in the MSBs.
package if_id_fetch_queue_pkg;

    localparam int PACKET_SIZE = 65;
    localparam int INSTR_COUNT = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        taken_branch;
    } fetched_packet_t;

    function automatic logic [1:0] popcount2(input logic [1:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]};
    endfunction

endpackage

// File: rtl/if_id_fetch_queue_mem.sv
// Purpose: DEPTH-entry packet register array with two write ports and two async read ports.
// Latency: a write lands at the clock edge, and its read data is visible after that edge.
// Backpressure: none; the owner guarantees that the two write indices never collide.
module fetch_queue_mem
    import if_id_fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr0_en,
    input  logic [AW-1:0]   wr0_idx,
    input  fetched_packet_t wr0_dat,
    input  logic            wr1_en,
    input  logic [AW-1:0]   wr1_idx,
    input  fetched_packet_t wr1_dat,
    input  logic [AW-1:0]   rd0_idx,
    output fetched_packet_t rd0_dat,
    input  logic [AW-1:0]   rd1_idx,
    output fetched_packet_t rd1_dat
);

    fetched_packet_t mem [DEPTH];

    // Cleared on reset so that data_o reads as zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr0_en) mem[wr0_idx] <= wr0_dat;
            if (wr1_en) mem[wr1_idx] <= wr1_dat;
        end
    end

    assign rd0_dat = mem[rd0_idx];
    assign rd1_dat = mem[rd1_idx];

endmodule

// File: rtl/if_id_fetch_queue.sv
// Purpose: IF->ID decoupling queue that compacts masked fetch lanes and presents the two oldest packets.
// Latency: 1 cycle from push to valid_o, with no bypass path.
// Backpressure: ready_o is driven only from the registered count and is high while count <= DEPTH-2.
module if_id_fetch_queue
    import if_id_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               valid_i,
    input  logic [INSTR_COUNT-1:0]             mask_i,
    input  logic [INSTR_COUNT*PACKET_SIZE-1:0] data_i,
    output logic                               ready_o,
    input  logic                               flush_i,
    output logic [INSTR_COUNT-1:0]             valid_o,
    output logic [INSTR_COUNT*PACKET_SIZE-1:0] data_o,
    input  logic                               ready_i,
    output logic [$clog2(DEPTH+1)-1:0]         count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            push_en;
    logic [1:0]      push_n, pop_n;
    fetched_packet_t lane0_in, lane1_in, rd0_dat, rd1_dat;

    assign lane0_in = fetched_packet_t'(data_i[PACKET_SIZE-1:0]);
    assign lane1_in = fetched_packet_t'(data_i[2*PACKET_SIZE-1:PACKET_SIZE]);

    assign ready_o = (count <= CW'(DEPTH-2));
    assign valid_o = {count >= CW'(2), count != '0};
    assign count_o = count;

    assign push_en = valid_i && ready_o && !flush_i;
    assign push_n  = push_en ? popcount2(mask_i) : 2'd0;
    assign pop_n   = (ready_i && !flush_i) ? popcount2(valid_o) : 2'd0;

    // A lone lane1 is compacted down into port 0, so the queue never holds holes.
    fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr0_en  (push_en && (mask_i != 2'b00)),
        .wr0_idx (wr_ptr),
        .wr0_dat (mask_i[0] ? lane0_in : lane1_in),
        .wr1_en  (push_en && (mask_i == 2'b11)),
        .wr1_idx (wr_ptr + AW'(1)),
        .wr1_dat (lane1_in),
        .rd0_idx (rd_ptr),
        .rd0_dat (rd0_dat),
        .rd1_idx (rd_ptr + AW'(1)),
        .rd1_dat (rd1_dat)
    );

    assign data_o = {rd1_dat, rd0_dat};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop_n);
            wr_ptr <= wr_ptr + AW'(push_n);
            count  <= count + CW'(push_n) - CW'(pop_n);
        end
    end

endmodule
